// File: rtl/generic_rs.sv
// generic_rs: reservation station for one execution unit.
// Buffers up to DEPTH issued instructions and snoops the CDB for missing
// operands. Dispatches the lowest-index ready entry over a valid/ready handshake.
// Optional feature macro: LEN5_RS_ISSUE_FWD_EN. When defined, a CDB broadcast
// in the issue cycle also resolves the operands of the instruction being written.
module generic_rs #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ROB_IDX_LEN    = 5,
  parameter int unsigned I_IMM          = 12,
  parameter int unsigned MAX_EU_CTL_LEN = 4,
  parameter int unsigned EU_CTL_LEN     = MAX_EU_CTL_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,

  // Issue side
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [EU_CTL_LEN-1:0]  issue_eu_ctl_i,
  input  logic                   issue_rs1_ready_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i,
  input  logic [XLEN-1:0]        issue_rs1_value_i,
  input  logic                   issue_rs2_ready_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i,
  input  logic [XLEN-1:0]        issue_rs2_value_i,
  input  logic [I_IMM-1:0]       issue_imm_value_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i,

  // Common data bus snoop
  input  logic                   cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0] cdb_rob_idx_i,
  input  logic [XLEN-1:0]        cdb_value_i,

  // Execution unit side
  output logic                   eu_valid_o,
  input  logic                   eu_ready_i,
  output logic [EU_CTL_LEN-1:0]  eu_eu_ctl_o,
  output logic [XLEN-1:0]        eu_rs1_value_o,
  output logic [XLEN-1:0]        eu_rs2_value_o,
  output logic [I_IMM-1:0]       eu_imm_value_o,
  output logic [ROB_IDX_LEN-1:0] eu_rob_idx_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Payload of one station entry; the valid bit is kept separately.
  typedef struct packed {
    logic [EU_CTL_LEN-1:0]  eu_ctl;
    logic                   rs1_ready;
    logic [ROB_IDX_LEN-1:0] rs1_idx;
    logic [XLEN-1:0]        rs1_value;
    logic                   rs2_ready;
    logic [ROB_IDX_LEN-1:0] rs2_idx;
    logic [XLEN-1:0]        rs2_value;
    logic [I_IMM-1:0]       imm;
    logic [ROB_IDX_LEN-1:0] rob_idx;
  } entry_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           data_q [DEPTH];
  entry_t           data_d [DEPTH];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_accept;
  logic             dispatch;
  entry_t           new_entry;

  // Lowest-index free slot and lowest-index dispatchable entry, from registered state only.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    // Scan downwards so the last hit, i.e. the lowest index, wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && data_q[i].rs1_ready && data_q[i].rs2_ready) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Handshake qualifiers.
  assign issue_ready_o = free_found;
  assign eu_valid_o    = sel_found;
  assign issue_accept  = issue_valid_i && free_found && !flush_i;
  assign dispatch      = sel_found && eu_ready_i;

  // Dispatch outputs: fields of the selected entry, all-zero when nothing is ready.
  always_comb begin
    eu_eu_ctl_o    = '0;
    eu_rs1_value_o = '0;
    eu_rs2_value_o = '0;
    eu_imm_value_o = '0;
    eu_rob_idx_o   = '0;
    if (sel_found) begin
      eu_eu_ctl_o    = data_q[sel_idx].eu_ctl;
      eu_rs1_value_o = data_q[sel_idx].rs1_value;
      eu_rs2_value_o = data_q[sel_idx].rs2_value;
      eu_imm_value_o = data_q[sel_idx].imm;
      eu_rob_idx_o   = data_q[sel_idx].rob_idx;
    end
  end

  // Build the entry written on issue accept, optionally forwarding a same-cycle CDB result.
  always_comb begin
    new_entry.eu_ctl    = issue_eu_ctl_i;
    new_entry.rs1_ready = issue_rs1_ready_i;
    new_entry.rs1_idx   = issue_rs1_idx_i;
    new_entry.rs1_value = issue_rs1_value_i;
    new_entry.rs2_ready = issue_rs2_ready_i;
    new_entry.rs2_idx   = issue_rs2_idx_i;
    new_entry.rs2_value = issue_rs2_value_i;
    new_entry.imm       = issue_imm_value_i;
    new_entry.rob_idx   = issue_rob_idx_i;
`ifdef LEN5_RS_ISSUE_FWD_EN
    if (!issue_rs1_ready_i && cdb_valid_i && (cdb_rob_idx_i == issue_rs1_idx_i)) begin
      new_entry.rs1_ready = 1'b1;
      new_entry.rs1_value = cdb_value_i;
    end
    if (!issue_rs2_ready_i && cdb_valid_i && (cdb_rob_idx_i == issue_rs2_idx_i)) begin
      new_entry.rs2_ready = 1'b1;
      new_entry.rs2_value = cdb_value_i;
    end
`else
    // Same-cycle CDB results are the issue logic's responsibility; the operand
    // is stored exactly as presented.
`endif
  end

  // Next state: wakeup, dispatch and issue touch disjoint entries; flush overrides all.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      if (valid_q[i] && cdb_valid_i) begin
        if (!data_q[i].rs1_ready && (data_q[i].rs1_idx == cdb_rob_idx_i)) begin
          data_d[i].rs1_ready = 1'b1;
          data_d[i].rs1_value = cdb_value_i;
        end
        if (!data_q[i].rs2_ready && (data_q[i].rs2_idx == cdb_rob_idx_i)) begin
          data_d[i].rs2_ready = 1'b1;
          data_d[i].rs2_value = cdb_value_i;
        end
      end
    end
    if (dispatch) begin
      valid_d[sel_idx] = 1'b0;
    end
    if (issue_accept) begin
      valid_d[free_idx] = 1'b1;
      data_d[free_idx]  = new_entry;
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Entry valid bits: synchronous reset, the only state that needs one.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk_i) begin
    // NOTE: payload is not reset; it is only observed through a set valid bit, and outputs are zero-gated.
    for (int i = 0; i < DEPTH; i++) begin
      data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_generic_rs.sv
// Directed self-checking bench for generic_rs (default parameters).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_generic_rs;

  localparam int XLEN = 32;
  localparam int ROB  = 5;
  localparam int IMM  = 12;
  localparam int CTL  = 4;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i;
  logic            issue_valid_i, issue_ready_o;
  logic [CTL-1:0]  issue_eu_ctl_i;
  logic            issue_rs1_ready_i, issue_rs2_ready_i;
  logic [ROB-1:0]  issue_rs1_idx_i, issue_rs2_idx_i, issue_rob_idx_i;
  logic [XLEN-1:0] issue_rs1_value_i, issue_rs2_value_i;
  logic [IMM-1:0]  issue_imm_value_i;
  logic            cdb_valid_i;
  logic [ROB-1:0]  cdb_rob_idx_i;
  logic [XLEN-1:0] cdb_value_i;
  logic            eu_valid_o, eu_ready_i;
  logic [CTL-1:0]  eu_eu_ctl_o;
  logic [XLEN-1:0] eu_rs1_value_o, eu_rs2_value_o;
  logic [IMM-1:0]  eu_imm_value_o;
  logic [ROB-1:0]  eu_rob_idx_o;

  int n_checks = 0;
  int n_errors = 0;

  generic_rs dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_eu_ctl_i    (issue_eu_ctl_i),
    .issue_rs1_ready_i (issue_rs1_ready_i),
    .issue_rs1_idx_i   (issue_rs1_idx_i),
    .issue_rs1_value_i (issue_rs1_value_i),
    .issue_rs2_ready_i (issue_rs2_ready_i),
    .issue_rs2_idx_i   (issue_rs2_idx_i),
    .issue_rs2_value_i (issue_rs2_value_i),
    .issue_imm_value_i (issue_imm_value_i),
    .issue_rob_idx_i   (issue_rob_idx_i),
    .cdb_valid_i       (cdb_valid_i),
    .cdb_rob_idx_i     (cdb_rob_idx_i),
    .cdb_value_i       (cdb_value_i),
    .eu_valid_o        (eu_valid_o),
    .eu_ready_i        (eu_ready_i),
    .eu_eu_ctl_o       (eu_eu_ctl_o),
    .eu_rs1_value_o    (eu_rs1_value_o),
    .eu_rs2_value_o    (eu_rs2_value_o),
    .eu_imm_value_o    (eu_imm_value_o),
    .eu_rob_idx_o      (eu_rob_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one instruction on the issue port (valid stays high until cleared).
  task automatic drive_issue(input logic [ROB-1:0] rob, input logic r1_rdy, input logic [ROB-1:0] r1_idx,
                             input logic [XLEN-1:0] r1_val, input logic r2_rdy, input logic [ROB-1:0] r2_idx,
                             input logic [XLEN-1:0] r2_val, input logic [IMM-1:0] imm, input logic [CTL-1:0] ctl);
    issue_valid_i     = 1'b1;
    issue_rob_idx_i   = rob;
    issue_rs1_ready_i = r1_rdy;
    issue_rs1_idx_i   = r1_idx;
    issue_rs1_value_i = r1_val;
    issue_rs2_ready_i = r2_rdy;
    issue_rs2_idx_i   = r2_idx;
    issue_rs2_value_i = r2_val;
    issue_imm_value_i = imm;
    issue_eu_ctl_i    = ctl;
  endtask

  task automatic cdb(input logic v, input logic [ROB-1:0] idx, input logic [XLEN-1:0] val);
    cdb_valid_i   = v;
    cdb_rob_idx_i = idx;
    cdb_value_i   = val;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; eu_ready_i = 1'b0;
    drive_issue('0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    issue_valid_i = 1'b0;
    cdb(1'b0, '0, '0);

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    check("rst_issue_ready", issue_ready_o, 1);
    check("rst_eu_valid", eu_valid_o, 0);
    check("rst_rs1", eu_rs1_value_o, 0);
    check("rst_rs2", eu_rs2_value_o, 0);
    check("rst_rob", eu_rob_idx_o, 0);
    check("rst_ctl", eu_eu_ctl_o, 0);
    check("rst_imm", eu_imm_value_o, 0);

    // Both operands ready: dispatch one cycle after issue
    eu_ready_i = 1'b1;
    drive_issue(5'd3, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7, 12'h012, 4'h2);
    tick();
    issue_valid_i = 1'b0;
    check("t1_valid", eu_valid_o, 1);
    check("t1_rs1", eu_rs1_value_o, 5);
    check("t1_rs2", eu_rs2_value_o, 7);
    check("t1_rob", eu_rob_idx_o, 3);
    check("t1_imm", eu_imm_value_o, 12'h012);
    check("t1_ctl", eu_eu_ctl_o, 2);
    tick();
    check("t1_freed", eu_valid_o, 0);
    check("t1_ready", issue_ready_o, 1);

    // rs1 waits on ROB 9; a broadcast for ROB 8 must not wake it
    drive_issue(5'd4, 1'b0, 5'd9, 32'hDEAD, 1'b1, 5'd0, 32'h22, 12'h0, 4'h1);
    tick();
    issue_valid_i = 1'b0;
    check("t2_wait", eu_valid_o, 0);
    cdb(1'b1, 5'd8, 32'h99);
    tick();
    check("t2_wrong_idx", eu_valid_o, 0);
    cdb(1'b1, 5'd9, 32'hAB);
    tick();
    cdb(1'b0, '0, '0);
    check("t2_valid", eu_valid_o, 1);
    check("t2_rs1", eu_rs1_value_o, 32'hAB);
    check("t2_rs2", eu_rs2_value_o, 32'h22);
    check("t2_rob", eu_rob_idx_o, 4);
    tick();
    check("t2_freed", eu_valid_o, 0);

    // Fill the station with the EU stalled, then drain in index order
    eu_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_issue(ROB'(10 + k), 1'b1, 5'd0, XLEN'(k + 1), 1'b1, 5'd0, XLEN'(100 + k), 12'h0, 4'h0);
      tick();
      check($sformatf("t3_ready_%0d", k), issue_ready_o, (k < 3) ? 1 : 0);
    end
    issue_valid_i = 1'b0;
    check("t3_stall_valid", eu_valid_o, 1);
    check("t3_stall_rob", eu_rob_idx_o, 10);
    tick();
    check("t3_stable_rob", eu_rob_idx_o, 10);
    check("t3_still_full", issue_ready_o, 0);
    eu_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_order_rob_%0d", k), eu_rob_idx_o, 10 + k);
      check($sformatf("t3_order_rs1_%0d", k), eu_rs1_value_o, k + 1);
      tick();
      if (k == 0) check("t3_ready_after_dispatch", issue_ready_o, 1);
    end
    check("t3_drained", eu_valid_o, 0);

    // Same-cycle CDB broadcast during issue
    drive_issue(5'd6, 1'b0, 5'd2, 32'h0, 1'b1, 5'd0, 32'h3, 12'h0, 4'h3);
    cdb(1'b1, 5'd2, 32'h11);
    tick();
    issue_valid_i = 1'b0;
    cdb(1'b0, '0, '0);
`ifdef LEN5_RS_ISSUE_FWD_EN
    check("t4_fwd_valid", eu_valid_o, 1);
    check("t4_fwd_rs1", eu_rs1_value_o, 32'h11);
    tick();
    check("t4_fwd_freed", eu_valid_o, 0);
`else
    check("t4_nofwd_wait", eu_valid_o, 0);
    tick();
    check("t4_nofwd_wait2", eu_valid_o, 0);
    cdb(1'b1, 5'd2, 32'h33);
    tick();
    cdb(1'b0, '0, '0);
    check("t4_nofwd_valid", eu_valid_o, 1);
    check("t4_nofwd_rs1", eu_rs1_value_o, 32'h33);
    check("t4_nofwd_rob", eu_rob_idx_o, 6);
    tick();
    check("t4_nofwd_freed", eu_valid_o, 0);
`endif

    // Flush with simultaneous issue and dispatch
    eu_ready_i = 1'b0;
    drive_issue(5'd20, 1'b0, 5'd30, 32'h0, 1'b1, 5'd0, 32'h1, 12'h0, 4'h0);
    tick();
    drive_issue(5'd21, 1'b0, 5'd31, 32'h0, 1'b1, 5'd0, 32'h1, 12'h0, 4'h0);
    tick();
    drive_issue(5'd22, 1'b1, 5'd0, 32'h7, 1'b1, 5'd0, 32'h8, 12'h0, 4'h0);
    tick();
    check("t5_pre_valid", eu_valid_o, 1);
    check("t5_pre_rob", eu_rob_idx_o, 22);
    drive_issue(5'd23, 1'b1, 5'd0, 32'h9, 1'b1, 5'd0, 32'h9, 12'h0, 4'h0);
    flush_i = 1'b1;
    eu_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    check("t5_valid", eu_valid_o, 0);
    check("t5_issue_ready", issue_ready_o, 1);
    check("t5_rob_zero", eu_rob_idx_o, 0);
    cdb(1'b1, 5'd30, 32'h5);
    tick();
    cdb(1'b0, '0, '0);
    check("t5_no_issue_kept", eu_valid_o, 0);
    tick();
    check("t5_no_wake_kept", eu_valid_o, 0);

    // One broadcast wakes both operands of the same entry
    drive_issue(5'd12, 1'b0, 5'd5, 32'h0, 1'b0, 5'd5, 32'h0, 12'h0, 4'h0);
    tick();
    issue_valid_i = 1'b0;
    check("t6_wait", eu_valid_o, 0);
    cdb(1'b1, 5'd5, 32'h42);
    tick();
    cdb(1'b0, '0, '0);
    check("t6_valid", eu_valid_o, 1);
    check("t6_rs1", eu_rs1_value_o, 32'h42);
    check("t6_rs2", eu_rs2_value_o, 32'h42);
    tick();
    check("t6_freed", eu_valid_o, 0);

    // Reset in the middle of a stalled handshake
    eu_ready_i = 1'b0;
    drive_issue(5'd1, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 12'h0, 4'h0);
    tick();
    issue_valid_i = 1'b0;
    check("t7_pending", eu_valid_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t7_dropped", eu_valid_o, 0);
    check("t7_issue_ready", issue_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
